// File: rtl/seq_controller.sv
// rtl/seq_controller.sv - multi-cycle sequencing controller for the Rockcessor core
module seq_controller #(
    parameter int OPW     = 4,
    parameter int BM_ROWS = 8,
    parameter int RW      = $clog2(BM_ROWS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [OPW-1:0] opcode,
    input  logic           dmem_ack,
    input  logic           ply_done,
    input  logic           go,
    output logic           pc_en,
    output logic           reg_write,
    output logic           bitmap_write,
    output logic           dmem_en,
    output logic           dmem_write,
    output logic [1:0]     sign_ex,
    output logic           ply_req,
    output logic [RW-1:0]  bm_row,
    output logic           busy,
    output logic           halted,
    output logic           illegal
);
    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_BMROW, S_PLYW, S_HALTED} state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_HALT = 4'h1, OP_SUB = 4'h2, OP_ADD = 4'h3,
                           OP_BRR = 4'h4, OP_BR   = 4'h5, OP_LD  = 4'h6, OP_ST  = 4'h7,
                           OP_PLY = 4'h8, OP_MV   = 4'h9, OP_BSL = 4'hA, OP_BSH = 4'hB,
                           OP_RET = 4'hC, OP_SES  = 4'hD, OP_STB = 4'hE, OP_LDB = 4'hF;
    localparam logic [RW-1:0] LAST_ROW = RW'(BM_ROWS - 1);

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_op;
    logic          r_ill;
    logic [RW-1:0] r_row, w_row_nxt;
    logic          r_gap, w_gap_nxt;
    logic          w_wide, w_bm_mem, w_last;

    // Any set bit above the 16-entry ISA marks the opcode illegal.
    generate
        if (OPW > 4) begin : g_wide
            assign w_wide = |opcode[OPW-1:4];
        end else begin : g_narrow
            assign w_wide = 1'b0;
        end
    endgenerate

    assign w_bm_mem = (r_op == OP_LDB) || (r_op == OP_STB);
    assign w_last   = (r_row == LAST_ROW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= 4'h0;
            r_ill   <= 1'b0;
            r_row   <= '0;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_gap   <= w_gap_nxt;
            if (r_state == S_FETCH && instr_valid) begin
                r_op  <= opcode[3:0];
                r_ill <= w_wide;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_gap_nxt   = r_gap;
        case (r_state)
            S_FETCH: if (instr_valid) w_state_nxt = S_EXEC;
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                w_row_nxt   = '0;
                w_gap_nxt   = 1'b1;  // memory-backed rows start with an idle cycle
                if (!r_ill) begin
                    case (r_op)
                        OP_LD, OP_ST:                   w_state_nxt = S_MEM;
                        OP_BSL, OP_BSH, OP_LDB, OP_STB: w_state_nxt = S_BMROW;
                        OP_PLY:                         w_state_nxt = S_PLYW;
                        OP_HALT:                        w_state_nxt = S_HALTED;
                        default:                        w_state_nxt = S_FETCH;
                    endcase
                end
            end
            S_MEM: if (dmem_ack) w_state_nxt = S_FETCH;
            S_BMROW: begin
                if (!w_bm_mem || (!r_gap && dmem_ack)) begin
                    w_gap_nxt = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_FETCH;
                        w_row_nxt   = '0;
                    end else begin
                        w_row_nxt = r_row + 1'b1;
                    end
                end else if (r_gap) begin
                    w_gap_nxt = 1'b0;
                end
            end
            S_PLYW:   if (ply_done) w_state_nxt = S_FETCH;
            S_HALTED: if (go) w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        instr_ready  = (r_state == S_FETCH);
        busy         = (r_state != S_FETCH) && (r_state != S_HALTED);
        halted       = (r_state == S_HALTED);
        bm_row       = r_row;
        pc_en        = 1'b0;
        reg_write    = 1'b0;
        bitmap_write = 1'b0;
        dmem_en      = 1'b0;
        dmem_write   = 1'b0;
        ply_req      = 1'b0;
        illegal      = 1'b0;
        sign_ex      = 2'b00;
        if (busy && !r_ill) begin
            case (r_op)
                OP_LD, OP_ST:   sign_ex = 2'b11;
                OP_LDB, OP_STB: sign_ex = 2'b10;
                OP_MV:          sign_ex = 2'b01;
                default:        sign_ex = 2'b00;
            endcase
        end
        case (r_state)
            S_EXEC: begin
                if (r_ill) begin
                    pc_en   = 1'b1;
                    illegal = 1'b1;
                end else begin
                    case (r_op)
                        OP_SUB, OP_ADD, OP_MV: begin
                            reg_write = 1'b1;
                            pc_en     = 1'b1;
                        end
                        OP_NOP, OP_BR, OP_BRR, OP_RET: pc_en = 1'b1;
                        OP_SES: begin
                            bitmap_write = 1'b1;
                            pc_en        = 1'b1;
                        end
                        default: pc_en = 1'b0;
                    endcase
                end
            end
            S_MEM: begin
                dmem_en    = 1'b1;
                dmem_write = (r_op == OP_ST);
                pc_en      = dmem_ack;
                reg_write  = dmem_ack && (r_op == OP_LD);
            end
            S_BMROW: begin
                if (!w_bm_mem) begin
                    bitmap_write = 1'b1;
                    pc_en        = w_last;
                end else if (!r_gap) begin
                    dmem_en      = 1'b1;
                    dmem_write   = (r_op == OP_STB);
                    bitmap_write = dmem_ack && (r_op == OP_LDB);
                    pc_en        = dmem_ack && w_last;
                end
            end
            S_PLYW: begin
                ply_req = 1'b1;
                pc_en   = ply_done;
            end
            S_HALTED: pc_en = go;
            default: pc_en = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_seq_controller.sv
// tb/tb_seq_controller.sv - self-checking bench for seq_controller
module tb_seq_controller;
    logic       clk = 1'b0;
    logic       rst, instr_valid, dmem_ack, ply_done, go;
    logic [4:0] opcode;
    logic       instr_ready, pc_en, reg_write, bitmap_write, dmem_en, dmem_write;
    logic       ply_req, busy, halted, illegal;
    logic [1:0] sign_ex;
    logic [2:0] bm_row;

    int n_chk = 0, n_fail = 0;
    int c_pc, c_rw, c_bw, c_den, c_dw, c_ply, c_halt, c_ill;

    seq_controller #(.OPW(5), .BM_ROWS(8)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .dmem_ack(dmem_ack), .ply_done(ply_done), .go(go),
        .pc_en(pc_en), .reg_write(reg_write), .bitmap_write(bitmap_write),
        .dmem_en(dmem_en), .dmem_write(dmem_write), .sign_ex(sign_ex),
        .ply_req(ply_req), .bm_row(bm_row), .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        logic       rw;
        logic       bw;
        logic       ill;
        logic [1:0] sx;
    } vec_t;
    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        c_pc = 0; c_rw = 0; c_bw = 0; c_den = 0; c_dw = 0; c_ply = 0; c_halt = 0; c_ill = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        c_pc += int'(pc_en); c_rw += int'(reg_write); c_bw += int'(bitmap_write);
        c_den += int'(dmem_en); c_dw += int'(dmem_write); c_ply += int'(ply_req);
        c_halt += int'(halted); c_ill += int'(illegal);
    endtask

    task automatic accept(input logic [4:0] op);
        opcode = op;
        instr_valid = 1'b1;
        @(negedge clk);
        chk("accept_ready", int'(instr_ready), 1);
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        int pc_at, rw_at, bad, beats, pc_beat, row_at_pc;
        logic p_den, p_ack, hit;
        rst = 1'b1; instr_valid = 1'b0; dmem_ack = 1'b0; ply_done = 1'b0; go = 1'b0; opcode = '0;
        vecs[0] = '{5'h00, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[1] = '{5'h02, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[2] = '{5'h03, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[3] = '{5'h04, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[4] = '{5'h05, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[5] = '{5'h09, 1'b1, 1'b0, 1'b0, 2'b01};
        vecs[6] = '{5'h0C, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[7] = '{5'h0D, 1'b0, 1'b1, 1'b0, 2'b00};
        vecs[8] = '{5'h13, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[9] = '{5'h1F, 1'b0, 1'b0, 1'b1, 2'b00};
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", int'(instr_ready), 1);
        chk("rst_outs", int'({pc_en, reg_write, bitmap_write, dmem_en, dmem_write, ply_req,
                              busy, halted, illegal}), 0);
        chk("rst_row_sx", int'({bm_row, sign_ex}), 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].op);
            @(negedge clk);
            chk($sformatf("single%0d_pc", i), int'(pc_en), 1);
            chk($sformatf("single%0d_rw", i), int'(reg_write), int'(vecs[i].rw));
            chk($sformatf("single%0d_bw", i), int'(bitmap_write), int'(vecs[i].bw));
            chk($sformatf("single%0d_ill", i), int'(illegal), int'(vecs[i].ill));
            chk($sformatf("single%0d_sx", i), int'(sign_ex), int'(vecs[i].sx));
            chk($sformatf("single%0d_mem", i), int'({dmem_en, ply_req, instr_ready}), 0);
            tick();
            @(negedge clk);
            chk($sformatf("single%0d_back", i), int'({instr_ready, pc_en}), 2);
            tick();
        end

        // ADD then SUB with instr_valid held high
        opcode = 5'h03; instr_valid = 1'b1;
        @(negedge clk); chk("as_c1", int'({instr_ready, pc_en, reg_write}), 4);
        tick(); opcode = 5'h02;
        @(negedge clk); chk("as_c2", int'({instr_ready, pc_en, reg_write}), 3);
        tick();
        @(negedge clk); chk("as_c3", int'({instr_ready, pc_en, reg_write}), 4);
        tick();
        @(negedge clk); chk("as_c4", int'({instr_ready, pc_en, reg_write}), 3);
        tick(); instr_valid = 1'b0;

        // LD with ack delayed five cycles
        accept(5'h06); clr(); rw_at = -1; bad = 0;
        for (int i = 0; i < 10; i++) begin
            dmem_ack = (i == 6);
            sample();
            if (reg_write) rw_at = i;
            if (busy && sign_ex != 2'b11) bad++;
            tick();
        end
        dmem_ack = 1'b0;
        chk("ld_den", c_den, 6); chk("ld_dw", c_dw, 0); chk("ld_rw", c_rw, 1);
        chk("ld_rw_at", rw_at, 6); chk("ld_pc", c_pc, 1); chk("ld_sx", bad, 0);

        // ST zero-wait
        accept(5'h07); clr(); pc_at = -1;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 1);
            sample();
            if (pc_en) pc_at = i;
            tick();
        end
        dmem_ack = 1'b0;
        chk("st_dw", c_dw, 1); chk("st_rw", c_rw, 0); chk("st_pc_at", pc_at, 1);

        // STB, ack one cycle after each request
        accept(5'h0E); clr(); p_den = 1'b0; p_ack = 1'b0; beats = 0; bad = 0; pc_beat = -1;
        for (int i = 0; i < 30; i++) begin
            dmem_ack = p_den && !p_ack;
            sample();
            if (dmem_en && dmem_ack) begin
                if (int'(bm_row) != beats) bad++;
                beats++;
            end
            if (pc_en) pc_beat = beats;
            if (dmem_en && (!dmem_write || sign_ex != 2'b10)) bad++;
            p_den = dmem_en; p_ack = dmem_ack;
            tick();
        end
        dmem_ack = 1'b0;
        chk("stb_beats", beats, 8); chk("stb_rows", bad, 0); chk("stb_bw", c_bw, 0);
        chk("stb_pc", c_pc, 1); chk("stb_pc_beat", pc_beat, 8); chk("stb_rw", c_rw, 0);

        // LDB zero-wait: 2*BM_ROWS+2 cycle latency
        accept(5'h0F); clr(); pc_at = -1; dmem_ack = 1'b1;
        for (int i = 0; i < 22; i++) begin
            sample();
            if (pc_en) pc_at = i + 2;
            tick();
        end
        dmem_ack = 1'b0;
        chk("ldb_latency", pc_at, 18); chk("ldb_bw", c_bw, 8); chk("ldb_den", c_den, 8);
        chk("ldb_pc", c_pc, 1); chk("ldb_rw", c_rw, 0);

        // reset held two cycles mid-LDB at bm_row 3
        accept(5'h0F); dmem_ack = 1'b1; hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (bm_row == 3'd3) hit = 1'b1;
            tick();
        end
        chk("rst_mid_reach", int'(hit), 1);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_row", int'(bm_row), 0);
        chk("rst_mid_outs", int'({dmem_en, instr_ready, pc_en}), 2);
        tick(); clr();
        for (int i = 0; i < 3; i++) begin sample(); tick(); end
        dmem_ack = 1'b0;
        chk("rst_mid_nopc", c_pc + c_bw + c_den, 0);

        // BSL
        accept(5'h0A); clr(); pc_at = -1; row_at_pc = -1;
        for (int i = 0; i < 12; i++) begin
            sample();
            if (pc_en) begin pc_at = i + 2; row_at_pc = int'(bm_row); end
            tick();
        end
        chk("bsl_latency", pc_at, 10); chk("bsl_bw", c_bw, 8); chk("bsl_row", row_at_pc, 7);
        chk("bsl_den", c_den, 0);

        // PLY with spurious go / dmem_ack
        accept(5'h08); clr(); pc_at = -1;
        for (int i = 0; i < 15; i++) begin
            ply_done = (i == 11); go = (i == 3) || (i == 7); dmem_ack = (i == 5) || (i == 9);
            sample();
            if (pc_en) pc_at = i;
            tick();
        end
        ply_done = 1'b0; go = 1'b0; dmem_ack = 1'b0;
        chk("ply_req", c_ply, 11); chk("ply_pc", c_pc, 1); chk("ply_pc_at", pc_at, 11);
        chk("ply_other", c_rw + c_bw + c_den + c_halt, 0);

        // HALT then go after four halted cycles
        accept(5'h01); clr(); pc_at = -1;
        for (int i = 0; i < 8; i++) begin
            go = (i == 0) || (i == 4);
            sample();
            if (pc_en) pc_at = i;
            tick();
        end
        go = 1'b0;
        chk("halt_cnt", c_halt, 4); chk("halt_pc", c_pc, 1); chk("halt_pc_at", pc_at, 4);
        @(negedge clk);
        chk("halt_back", int'({instr_ready, halted, busy}), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
